vga_timing_gen: RTL
===================

# vga_timing_gen

Generates the 640x480@60 Hz VGA raster that drives the pixel pipeline: pixel_x, pixel_y, display_enable and frame/line strobes go to graphics_mixer. The block samples the mixer's 8-bit RRRGGGBB result on each pixel tick, expands it to 4:4:4 and drives the VGA pins. Sync pulses are delayed to stay aligned with the colour. It closes the loop between the system clock domain and the display connector.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- CLK_DIV, 2, clk cycles per pixel (≥1)
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- pixel_color_in_332  in  8  mixer output, RRRGGGBB
- test_pattern_en  in  1  selects colour bars (only with the macro)
- pixel_tick  out  1  one-clk strobe; the raster advances at the end of this cycle
- pixel_x  out  10  h_count, 0..799
- pixel_y  out  10  v_count, 0..524
- display_enable  out  1  h_count<H_ACTIVE && v_count<V_ACTIVE
- line_start  out  1  pixel_tick && h_count==0
- frame_start  out  1  pixel_tick && h_count==0 && v_count==0
- vga_r / vga_g / vga_b  out  4 each  registered colour
- vga_hsync / vga_vsync  out  1 each  registered sync, active-low

## Operation
- Divider div_cnt counts 0..CLK_DIV-1 and wraps. pixel_tick = (div_cnt==CLK_DIV-1). With CLK_DIV=1, pixel_tick is constant 1 after reset.
- On pixel_tick, h_count increments. At H_TOTAL-1 (799) it wraps to 0 and v_count increments. v_count wraps from V_TOTAL-1 (524) to 0 when h also wraps.
- Reset values:
  - div_cnt=0; h_count=799, v_count=524, so the raster sits on the last blanking pixel.
  - Therefore display_enable=0, line_start=0, frame_start=0.
  - vga_hsync=vga_vsync=1; vga_r/g/b=0.
- pixel_x, pixel_y, display_enable, line_start and frame_start are decodes of flops with zero added latency. The mixer is combinational within the same pixel.
- On pixel_tick, the output stage registers:
  - hsync_n ← !(656 ≤ h_count ≤ 751)
  - vsync_n ← !(490 ≤ v_count ≤ 491)
  - if display_enable: r ← {R[2:0],R[2]}, g ← {G[2:0],G[2]}, b ← {B[1:0],B[1:0]}; otherwise r=g=b ← 0.
- Sync window bounds derive from the parameters (H_ACTIVE+H_FP … +H_SYNC-1); the values above are the defaults.
- Output registers hold their value between ticks.
- Counter arithmetic is unsigned 10-bit; H_TOTAL and V_TOTAL must be ≤1023.

## Timing
- Pins show pixel N exactly one pixel period (CLK_DIV clk) after pixel_x/pixel_y present N. Sync and colour share this delay.
- First pixel_tick after reset release: CLK_DIV-1 cycles later (cycle 1 at CLK_DIV=2). frame_start is not asserted on that tick, because the counters are still at (799,524).
- The counters reach (0,0) after that first tick. frame_start asserts on the next tick, ending pixel (0,0).
- Frame period: 800×525×CLK_DIV clk (840 000 at CLK_DIV=2).
- Reset mid-frame: on the following edge, all state returns to reset values regardless of position. A reset asserted in the same cycle as pixel_tick wins.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - While test_pattern_en=1, colour bars replace pixel_color_in_332 before expansion.
  - Bar index = pixel_x/80 (comparator chain, no divider), giving 8 bars.
  - Bar colours: FF, FC, 1F, 1C, E3, E0, 03, 00.
- Undefined: test_pattern_en is present but ignored, and no bar logic is synthesised.

## Structure
- Shared package vga_pkg:
  - default timing constants, H_TOTAL and V_TOTAL;
  - the RRRGGGBB→4:4:4 expansion function;
  - the bar colour constants.
- Optional sub-module vga_color_expand: the combinational 332→444 expansion plus the test-pattern mux. Counters and output registers stay in vga_timing_gen.

## Test plan
- Reset held 5 cycles → pixel_x=799, pixel_y=524, display_enable=0, hsync=vsync=1, rgb=0. After release: pixel_tick at cycle 1, then pixel_x=0, pixel_y=0, and frame_start on the following tick.
- Free run one line → 800 ticks between hsync falling edges, hsync low for 96 ticks, display_enable high for 640 ticks, line_start once per line.
- Free run one frame → 525 lines; vsync low for lines 490–491, delayed one pixel; frame_start spacing 840 000 clk at CLK_DIV=2.
- Drive 8'b101_110_01 during active video → one pixel later r=4'b1011, g=4'b1101, b=4'b0101. Drive 8'hFF during blanking → rgb=0.
- Assert rst for one cycle at (300,200) → next edge pixel_x=799, pixel_y=524, outputs at reset values, and the raster restarts cleanly.
- With VGA_TEST_PATTERN_EN defined and test_pattern_en=1 → x=0..79 gives rgb=FFF and x=560..639 gives 000. Without the macro, the same stimulus passes pixel_color_in_332 through unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, bar colours and the RRRGGGBB -> 4:4:4 expansion.
package vga_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int H_FP_DEFAULT     = 16;
  localparam int H_SYNC_DEFAULT   = 96;
  localparam int H_BP_DEFAULT     = 48;
  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int V_FP_DEFAULT     = 10;
  localparam int V_SYNC_DEFAULT   = 2;
  localparam int V_BP_DEFAULT     = 33;
  localparam int CLK_DIV_DEFAULT  = 2;

  localparam int H_TOTAL = H_ACTIVE_DEFAULT + H_FP_DEFAULT + H_SYNC_DEFAULT + H_BP_DEFAULT;
  localparam int V_TOTAL = V_ACTIVE_DEFAULT + V_FP_DEFAULT + V_SYNC_DEFAULT + V_BP_DEFAULT;

  localparam logic [7:0] BAR_COLORS [0:7] = '{
    8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00
  };

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Replicate the top bits so full-scale 3-bit/2-bit values map to 4'hF.
  function automatic rgb444_t expand_332(input logic [7:0] c);
    rgb444_t o;
    o.r = {c[7:5], c[7]};
    o.g = {c[4:2], c[4]};
    o.b = {c[1:0], c[1:0]};
    return o;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-pipeline and VGA pin bundle between the timing generator and its neighbours.
interface vga_timing_if;
  logic       pixel_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       display_enable;
  logic       line_start;
  logic       frame_start;
  logic [7:0] pixel_color_in_332;
  logic       test_pattern_en;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hsync;
  logic       vga_vsync;

  modport master (
    output pixel_tick, pixel_x, pixel_y, display_enable, line_start, frame_start,
    output vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
    input  pixel_color_in_332, test_pattern_en
  );

  modport slave (
    input  pixel_tick, pixel_x, pixel_y, display_enable, line_start, frame_start,
    input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
    output pixel_color_in_332, test_pattern_en
  );
endinterface

// File: rtl/vga_timing_gen_color_expand.sv
// Combinational 332 -> 444 expansion with optional colour-bar substitution.
// Bars are built only when VGA_TEST_PATTERN_EN is defined.
import vga_pkg::*;

module vga_color_expand (
  input  logic [9:0] pixel_x,
  input  logic [7:0] color_in,
  input  logic       test_pattern_en,
  output rgb444_t    color_out
);

  logic [7:0] color_sel;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx;

  // 80-pixel-wide bars from a comparator chain rather than a divider.
  always_comb begin
    bar_idx = 3'd7;
    if      (pixel_x < 10'd80)  bar_idx = 3'd0;
    else if (pixel_x < 10'd160) bar_idx = 3'd1;
    else if (pixel_x < 10'd240) bar_idx = 3'd2;
    else if (pixel_x < 10'd320) bar_idx = 3'd3;
    else if (pixel_x < 10'd400) bar_idx = 3'd4;
    else if (pixel_x < 10'd480) bar_idx = 3'd5;
    else if (pixel_x < 10'd560) bar_idx = 3'd6;
  end

  assign color_sel = test_pattern_en ? BAR_COLORS[bar_idx] : color_in;
`else
  logic unused_pattern_inputs;
  assign unused_pattern_inputs = &{1'b0, test_pattern_en, pixel_x};
  assign color_sel = color_in;
`endif

  assign color_out = expand_332(color_sel);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: pixel divider, h/v counters and one-pixel output stage.
// Optional colour bars selected at build time with VGA_TEST_PATTERN_EN.
import vga_pkg::*;

module vga_timing_gen #(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int H_FP     = H_FP_DEFAULT,
  parameter int H_SYNC   = H_SYNC_DEFAULT,
  parameter int H_BP     = H_BP_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int V_FP     = V_FP_DEFAULT,
  parameter int V_SYNC   = V_SYNC_DEFAULT,
  parameter int V_BP     = V_BP_DEFAULT,
  parameter int CLK_DIV  = CLK_DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master bus
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_count;
  logic [9:0]       v_count;
  logic             pixel_tick;
  logic             display_enable;
  rgb444_t          rgb_next;
  rgb444_t          rgb_q;
  logic             hsync_q;
  logic             vsync_q;

  assign pixel_tick     = (div_cnt == DIV_LAST);
  assign display_enable = (h_count < H_VIS) && (v_count < V_VIS);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (pixel_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Reset parks the raster on the final blanking pixel so the first tick lands on (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      h_count <= H_LAST;
      v_count <= V_LAST;
    end else if (pixel_tick) begin
      if (h_count == H_LAST) begin
        h_count <= '0;
        v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 10'd1;
      end
    end
  end

  vga_color_expand u_color_expand (
    .pixel_x         (h_count),
    .color_in        (bus.pixel_color_in_332),
    .test_pattern_en (bus.test_pattern_en),
    .color_out       (rgb_next)
  );

  // Sync shares the colour's one-pixel delay so pins stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pixel_tick) begin
      hsync_q <= !((h_count >= HS_FIRST) && (h_count <= HS_LAST));
      vsync_q <= !((v_count >= VS_FIRST) && (v_count <= VS_LAST));
      rgb_q   <= display_enable ? rgb_next : '0;
    end
  end

  assign bus.pixel_tick     = pixel_tick;
  assign bus.pixel_x        = h_count;
  assign bus.pixel_y        = v_count;
  assign bus.display_enable = display_enable;
  assign bus.line_start     = pixel_tick && (h_count == 10'd0);
  assign bus.frame_start    = pixel_tick && (h_count == 10'd0) && (v_count == 10'd0);
  assign bus.vga_r          = rgb_q.r;
  assign bus.vga_g          = rgb_q.g;
  assign bus.vga_b          = rgb_q.b;
  assign bus.vga_hsync      = hsync_q;
  assign bus.vga_vsync      = vsync_q;

endmodule
